// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction fetch port and a data load/store port.
// Only one read may be outstanding; its response is routed back to the requester that issued it.
module mem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              iram_req,
    input  logic [XLEN-1:0]   iram_addr,
    output logic              iram_ready,
    output logic              iram_rvalid,
    output logic [XLEN-1:0]   iram_rdata,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_ready,
    output logic              dram_rvalid,
    output logic [XLEN-1:0]   dram_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t        state_reg, state_next;
    logic          last_d_reg, last_d_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;

    logic          waiting, issue_ok, prefer_d, grant_d, grant_i, accept, timeout_hit;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        waiting  = (state_reg != IDLE);
        // Gated by rst_b so nothing leaks out combinationally while reset is held.
        issue_ok = rst_b & (~waiting | bus_rvalid);
        prefer_d = (ARB_MODE == 0) ? 1'b1 : ~last_d_reg;
        grant_d  = issue_ok & dram_req & (~iram_req | prefer_d);
        grant_i  = issue_ok & iram_req & ~grant_d;

        bus_req    = grant_d | grant_i;
        bus_write  = grant_d & dram_write;
        bus_wstrb  = grant_d ? dram_wstrb : '0;
        bus_addr   = grant_d ? dram_addr  : iram_addr;
        bus_wdata  = grant_d ? dram_wdata : '0;
        iram_ready = grant_i & bus_ready;
        dram_ready = grant_d & bus_ready;
        accept     = bus_req & bus_ready;

        iram_rvalid = rst_b & bus_rvalid & (state_reg == WAIT_I);
        dram_rvalid = rst_b & bus_rvalid & (state_reg == WAIT_D);
        iram_rdata  = bus_rdata;
        dram_rdata  = bus_rdata;
        bus_err     = err_reg;

        cnt_inc     = cnt_reg + 1'b1;
        timeout_hit = (TIMEOUT != 0) && waiting && !bus_rvalid && (cnt_inc == CNT_MAX);

        state_next = state_reg;
        if (waiting && (bus_rvalid || timeout_hit))
            state_next = IDLE;
        if (accept) begin
            if (grant_i)
                state_next = WAIT_I;
            else
                state_next = dram_write ? IDLE : WAIT_D;
        end

        // A new read is accepted only from IDLE or on a response cycle, so clearing here
        // always lines up with entry into a wait state.
        if (state_next == IDLE || accept)
            cnt_next = '0;
        else if (cnt_reg != CNT_MAX)
            cnt_next = cnt_inc;
        else
            cnt_next = cnt_reg;

        err_next    = err_reg | (~waiting & bus_rvalid) | timeout_hit;
        last_d_next = accept ? grant_d : last_d_reg;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority/timeout instance (dut0) and round-robin instance (dut1).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        iram_req, dram_req, dram_write, bus_ready, bus_rvalid;
    logic [31:0] iram_addr, dram_addr, dram_wdata, bus_rdata;
    logic [3:0]  dram_wstrb;

    logic        iram_ready0, iram_rvalid0, dram_ready0, dram_rvalid0, bus_req0, bus_write0, bus_err0;
    logic [31:0] iram_rdata0, dram_rdata0, bus_addr0, bus_wdata0;
    logic [3:0]  bus_wstrb0;
    logic        iram_ready1, iram_rvalid1, dram_ready1, dram_rvalid1, bus_req1, bus_write1, bus_err1;
    logic [31:0] iram_rdata1, dram_rdata1, bus_addr1, bus_wdata1;
    logic [3:0]  bus_wstrb1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .ARB_MODE(0), .TIMEOUT(4)) dut0 (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_addr(iram_addr), .iram_ready(iram_ready0),
        .iram_rvalid(iram_rvalid0), .iram_rdata(iram_rdata0),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready0),
        .dram_rvalid(dram_rvalid0), .dram_rdata(dram_rdata0),
        .bus_req(bus_req0), .bus_write(bus_write0), .bus_wstrb(bus_wstrb0),
        .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err0)
    );

    mem_port_arbiter #(.XLEN(32), .ARB_MODE(1), .TIMEOUT(255)) dut1 (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_addr(iram_addr), .iram_ready(iram_ready1),
        .iram_rvalid(iram_rvalid1), .iram_rdata(iram_rdata1),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready1),
        .dram_rvalid(dram_rvalid1), .dram_rdata(dram_rdata1),
        .bus_req(bus_req1), .bus_write(bus_write1), .bus_wstrb(bus_wstrb1),
        .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iram_req = 0; iram_addr = 0; dram_req = 0; dram_write = 0; dram_wstrb = 0;
        dram_addr = 0; dram_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_b = 0;
        #2;
        rst_b = 1;
        tick();
    endtask

    task automatic test_reset();
        rst_b = 0;
        clear_inputs();
        iram_req = 1; dram_req = 1; bus_ready = 1; bus_rvalid = 1;
        #2;
        tests++; if (bus_req0 !== 1'b0) begin fails++; $display("FAIL reset_bus_req got %0b exp 0", bus_req0); end
        tests++; if ({iram_ready0, dram_ready0} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", {iram_ready0, dram_ready0}); end
        tests++; if ({iram_rvalid0, dram_rvalid0} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b exp 00", {iram_rvalid0, dram_rvalid0}); end
        tests++; if (bus_err0 !== 1'b0) begin fails++; $display("FAIL reset_err got %0b exp 0", bus_err0); end
        clear_inputs();
        rst_b = 1;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_fixed_prio();
        do_reset();
        iram_req = 1; iram_addr = 32'h100;
        dram_req = 1; dram_write = 0; dram_addr = 32'h2000; bus_ready = 1;
        #1;
        tests++; if ({dram_ready0, iram_ready0} !== 2'b10) begin fails++; $display("FAIL fp_c0_grant got %b exp 10", {dram_ready0, iram_ready0}); end
        tests++; if (bus_addr0 !== 32'h2000) begin fails++; $display("FAIL fp_c0_addr got %h exp 00002000", bus_addr0); end
        tick();
        dram_req = 0;
        #1;
        tests++; if ({bus_req0, iram_ready0} !== 2'b00) begin fails++; $display("FAIL fp_c1_blocked got %b exp 00", {bus_req0, iram_ready0}); end
        tick();
        bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        #1;
        tests++; if ({dram_rvalid0, iram_rvalid0} !== 2'b10) begin fails++; $display("FAIL fp_c2_rvalid got %b exp 10", {dram_rvalid0, iram_rvalid0}); end
        tests++; if (dram_rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL fp_c2_rdata got %h exp deadbeef", dram_rdata0); end
        tests++; if (iram_ready0 !== 1'b1) begin fails++; $display("FAIL fp_c2_iready got %0b exp 1", iram_ready0); end
        tests++; if ({bus_addr0, bus_wstrb0, bus_write0} !== {32'h100, 4'h0, 1'b0}) begin fails++; $display("FAIL fp_c2_fields got %h/%h/%0b exp 00000100/0/0", bus_addr0, bus_wstrb0, bus_write0); end
        tick();
        iram_req = 0; bus_rvalid = 0;
        tick();
        bus_rvalid = 1; bus_rdata = 32'h1234;
        #1;
        tests++; if ({iram_rvalid0, dram_rvalid0} !== 2'b10) begin fails++; $display("FAIL fp_i_rvalid got %b exp 10", {iram_rvalid0, dram_rvalid0}); end
        tests++; if (iram_rdata0 !== 32'h1234) begin fails++; $display("FAIL fp_i_rdata got %h exp 00001234", iram_rdata0); end
        tick();
        bus_rvalid = 0;
        #1;
        tests++; if (bus_err0 !== 1'b0) begin fails++; $display("FAIL fp_err got %0b exp 0", bus_err0); end
        $display("[TB] test_fixed_prio done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_d;
        do_reset();
        exp_d = 4'b0101;  // bit i = data expected to win cycle i: D, I, D, I
        iram_req = 1; iram_addr = 32'h200; dram_req = 1; dram_addr = 32'h2400; bus_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus_rvalid = (i != 0);
            #1;
            tests++; if ({dram_ready1, iram_ready1} !== {exp_d[i], ~exp_d[i]}) begin fails++; $display("FAIL rr_grant%0d got %b exp %b", i, {dram_ready1, iram_ready1}, {exp_d[i], ~exp_d[i]}); end
            tests++; if (dram_ready0 !== 1'b1) begin fails++; $display("FAIL fp_always_d%0d got %0b exp 1", i, dram_ready0); end
            if (i != 0) begin
                tests++; if ({dram_rvalid1, iram_rvalid1} !== {exp_d[i-1], ~exp_d[i-1]}) begin fails++; $display("FAIL rr_rvalid%0d got %b exp %b", i, {dram_rvalid1, iram_rvalid1}, {exp_d[i-1], ~exp_d[i-1]}); end
            end
            tick();
        end
        iram_req = 0; dram_req = 0; bus_rvalid = 1;
        tick();
        bus_rvalid = 0;
        #1;
        tests++; if (bus_err1 !== 1'b0) begin fails++; $display("FAIL rr_err got %0b exp 0", bus_err1); end
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_store_then_fetch();
        do_reset();
        dram_req = 1; dram_write = 1; dram_wstrb = 4'b0011; dram_addr = 32'h3000;
        dram_wdata = 32'hCAFEF00D; bus_ready = 1;
        #1;
        tests++; if (dram_ready0 !== 1'b1) begin fails++; $display("FAIL st_ready got %0b exp 1", dram_ready0); end
        tests++; if ({bus_write0, bus_wstrb0, bus_addr0, bus_wdata0} !== {1'b1, 4'b0011, 32'h3000, 32'hCAFEF00D}) begin fails++; $display("FAIL st_fields got %0b/%b/%h/%h exp 1/0011/00003000/cafef00d", bus_write0, bus_wstrb0, bus_addr0, bus_wdata0); end
        tick();
        dram_req = 0; dram_write = 0; dram_wstrb = 0; iram_req = 1; iram_addr = 32'h104;
        #1;
        tests++; if (iram_ready0 !== 1'b1) begin fails++; $display("FAIL st_fetch_ready got %0b exp 1", iram_ready0); end
        tests++; if ({bus_write0, bus_wdata0} !== {1'b0, 32'h0}) begin fails++; $display("FAIL st_fetch_fields got %0b/%h exp 0/00000000", bus_write0, bus_wdata0); end
        tests++; if (dram_rvalid0 !== 1'b0) begin fails++; $display("FAIL st_no_rvalid got %0b exp 0", dram_rvalid0); end
        tick();
        iram_req = 0; bus_rvalid = 1; bus_rdata = 32'h55AA;
        #1;
        tests++; if ({iram_rvalid0, dram_rvalid0} !== 2'b10) begin fails++; $display("FAIL st_fetch_rvalid got %b exp 10", {iram_rvalid0, dram_rvalid0}); end
        tick();
        bus_rvalid = 0;
        iram_req = 1; bus_ready = 0;
        #1;
        tests++; if ({bus_req0, iram_ready0} !== 2'b10) begin fails++; $display("FAIL stall got %b exp 10", {bus_req0, iram_ready0}); end
        tick();
        iram_req = 0;
        $display("[TB] test_store_then_fetch done");
    endtask

    task automatic test_timeout();
        do_reset();
        dram_req = 1; dram_write = 0; dram_addr = 32'h4000; bus_ready = 1;
        #1;
        tests++; if (dram_ready0 !== 1'b1) begin fails++; $display("FAIL to_accept got %0b exp 1", dram_ready0); end
        tick();
        dram_req = 0; iram_req = 1; iram_addr = 32'h108; bus_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            tests++; if ({bus_req0, dram_rvalid0, bus_err0} !== 3'b000) begin fails++; $display("FAIL to_wait%0d got %b exp 000", i, {bus_req0, dram_rvalid0, bus_err0}); end
            tick();
        end
        #1;
        tests++; if ({bus_req0, bus_err0} !== 2'b11) begin fails++; $display("FAIL to_idle got %b exp 11", {bus_req0, bus_err0}); end
        iram_req = 0; bus_rvalid = 1;
        #1;
        tests++; if ({iram_rvalid0, dram_rvalid0} !== 2'b00) begin fails++; $display("FAIL to_late_rvalid got %b exp 00", {iram_rvalid0, dram_rvalid0}); end
        tick();
        bus_rvalid = 0;
        $display("[TB] test_timeout done");
    endtask

    task automatic test_unsolicited();
        do_reset();
        bus_rvalid = 1; bus_rdata = 32'h77;
        #1;
        tests++; if ({iram_rvalid0, dram_rvalid0, bus_err0} !== 3'b000) begin fails++; $display("FAIL us_drop got %b exp 000", {iram_rvalid0, dram_rvalid0, bus_err0}); end
        tick();
        bus_rvalid = 0;
        #1;
        tests++; if (bus_err0 !== 1'b1) begin fails++; $display("FAIL us_err got %0b exp 1", bus_err0); end
        tick();
        tests++; if (bus_err0 !== 1'b1) begin fails++; $display("FAIL us_sticky got %0b exp 1", bus_err0); end
        $display("[TB] test_unsolicited done");
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        iram_req = 1; iram_addr = 32'h10C; bus_ready = 1;
        #1;
        tests++; if (iram_ready0 !== 1'b1) begin fails++; $display("FAIL rw_accept got %0b exp 1", iram_ready0); end
        tick();
        bus_rvalid = 1; bus_rdata = 32'h99;
        #1;
        tests++; if (iram_rvalid0 !== 1'b1) begin fails++; $display("FAIL rw_pre got %0b exp 1", iram_rvalid0); end
        rst_b = 0;
        #1;
        tests++; if ({bus_req0, iram_ready0, dram_ready0, iram_rvalid0, dram_rvalid0} !== 5'b0) begin fails++; $display("FAIL rw_zero got %b exp 00000", {bus_req0, iram_ready0, dram_ready0, iram_rvalid0, dram_rvalid0}); end
        #1;
        rst_b = 1; iram_req = 0;
        #1;
        tests++; if ({iram_rvalid0, dram_rvalid0, bus_err0} !== 3'b000) begin fails++; $display("FAIL rw_post_drop got %b exp 000", {iram_rvalid0, dram_rvalid0, bus_err0}); end
        tick();
        bus_rvalid = 0;
        #1;
        tests++; if (bus_err0 !== 1'b1) begin fails++; $display("FAIL rw_post_err got %0b exp 1", bus_err0); end
        $display("[TB] test_reset_in_wait done");
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_store_then_fetch();
        test_timeout();
        test_unsolicited();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
